// File: rtl/t02_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// States and grant owner encodings.
package t02_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/t02_arb_watchdog.sv
// Transaction watchdog: counts waiting cycles,
// flags expiry on the TIMEOUT-th one.
module t02_arb_watchdog #(
  parameter int TIMEOUT = 255,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

  assign expire = inc && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/t02_mem_arbiter.sv
// Shares one wishbone manager port between fetch
// and data; data first, burst limit for fetch.
module t02_mem_arbiter
  import t02_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  output logic              timeout_err
);

  localparam int BW = $clog2(MAX_D_BURST + 1);

  arb_state_t        state, next;
  owner_t            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [BW-1:0]     burst_q;

  logic waiting;
  logic expire;
  logic grant_i;
  logic can_grant;
  logic take;

  assign waiting   = (state == WAIT_START) ||
                     (state == WAIT_DONE);
  assign grant_i   = i_req &&
                     (!d_req ||
                      burst_q == BW'(MAX_D_BURST));
  assign can_grant = en && !mem_busy &&
                     (d_req || i_req);
  assign take      = (state == IDLE) && can_grant;

  t02_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (!waiting),
    .inc   (waiting),
    .expire(expire)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE:       if (can_grant) next = ISSUE;
      ISSUE:      next = WAIT_START;
      WAIT_START: begin
        if (expire)        next = DONE;
        else if (mem_busy) next = WAIT_DONE;
      end
      WAIT_DONE:  if (expire || !mem_busy)
                    next = DONE;
      DONE:       next = IDLE;
      default:    next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner_q     <= OWN_I;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      burst_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= next;
      if (take) begin
        owner_q <= grant_i ? OWN_I : OWN_D;
        addr_q  <= grant_i ? i_addr : d_addr;
        wdata_q <= grant_i ? '0 : d_wdata;
        we_q    <= grant_i ? 1'b0 : d_we;
      end
      // Burst only counts data grants that held off a fetch
      if (!i_req)
        burst_q <= '0;
      else if (take)
        burst_q <= grant_i ? '0 : burst_q + 1'b1;
      if (waiting && expire) begin
        rdata_q     <= '0;
        timeout_err <= 1'b1;
      end else if (state == WAIT_DONE && !mem_busy) begin
        rdata_q <= we_q ? '0 : mem_rdata;
      end
    end
  end

  assign mem_addr  = (state != IDLE) ? addr_q : '0;
  assign mem_wdata = (state != IDLE) ? wdata_q : '0;
  assign mem_ren   = (state == ISSUE) && !we_q;
  assign mem_wen   = (state == ISSUE) && we_q;
  assign i_ready   = (state == DONE) && (owner_q == OWN_I);
  assign d_ready   = (state == DONE) && (owner_q == OWN_D);
  assign i_rdata   = i_ready ? rdata_q : '0;
  assign d_rdata   = d_ready ? rdata_q : '0;

endmodule

// File: tb/tb_t02_mem_arbiter.sv
// Directed bench for t02_mem_arbiter with a
// simple wishbone manager busy model.
module tb_t02_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  logic        mgr_hang = 1'b0;
  int          mgr_busy_cycles = 3;
  logic [31:0] mgr_rdata = 32'h0;

  t02_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ready    (d_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .mem_busy   (mem_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Manager: busy from the cycle after the strobe
  initial begin
    mem_busy  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if ((mem_ren || mem_wen) && !mgr_hang) begin
        for (int k = 0; k < mgr_busy_cycles; k++) begin
          @(posedge clk); #1;
          mem_busy = 1'b1;
        end
        @(posedge clk); #1;
        mem_busy  = 1'b0;
        mem_rdata = mgr_rdata;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    int          n;
    int          ng;
    int          both;
    logic        got_i [10];
    logic        exp_i [10];

    rst     = 1'b1;
    en      = 1'b1;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    tick; tick;
    chk("rst_ren", mem_ren, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdy", {i_ready, d_ready}, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;
    tick;

    // 1: fetch only
    mgr_busy_cycles = 3;
    mgr_rdata = 32'h0000_0013;
    i_addr = 32'h3300_0000;
    i_req  = 1'b1;
    tick;
    chk("f_ren", mem_ren, 1);
    chk("f_wen", mem_wen, 0);
    chk("f_addr", mem_addr, 32'h3300_0000);
    tick;
    chk("f_ren_1cyc", mem_ren, 0);
    tick; tick; tick;
    chk("f_rdy_early", i_ready, 0);
    tick;
    chk("f_rdy", i_ready, 1);
    chk("f_rdata", i_rdata, 32'h13);
    chk("f_drdy", d_ready, 0);
    i_req = 1'b0;
    tick;
    chk("f_rdy_pulse", i_ready, 0);
    chk("f_idle_addr", mem_addr, 0);

    // 2: store
    mgr_rdata = 32'h5555_5555;
    d_addr  = 32'h3300_0040;
    d_wdata = 32'hCAFE_F00D;
    d_we    = 1'b1;
    d_req   = 1'b1;
    tick;
    chk("s_wen", mem_wen, 1);
    chk("s_ren", mem_ren, 0);
    chk("s_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("s_addr", mem_addr, 32'h3300_0040);
    tick;
    chk("s_wen_1cyc", mem_wen, 0);
    chk("s_wdata_hold", mem_wdata, 32'hCAFE_F00D);
    tick; tick; tick; tick;
    chk("s_rdy", d_ready, 1);
    chk("s_rdata", d_rdata, 0);
    chk("s_irdy", i_ready, 0);
    d_req = 1'b0;
    tick;
    chk("s_rdy_pulse", d_ready, 0);
    chk("s_idle_wdata", mem_wdata, 0);

    // 3: contention, D x4 then I
    mgr_busy_cycles = 1;
    mgr_rdata = 32'h1;
    d_we   = 1'b0;
    d_addr = 32'h3300_0040;
    i_addr = 32'h3300_0000;
    d_req  = 1'b1;
    i_req  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      got_i[k] = 1'b0;
      exp_i[k] = (k == 4) || (k == 9);
    end
    ng   = 0;
    both = 0;
    for (int c = 0; c < 300 && ng < 10; c++) begin
      tick;
      if (i_ready && d_ready) both++;
      if (mem_ren || mem_wen) begin
        got_i[ng] = (mem_addr == 32'h3300_0000);
        ng++;
      end
    end
    chk("c_ngrants", ng, 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("c_grant%0d_is_i", k),
          got_i[k], exp_i[k]);
    chk("c_both_rdy", both, 0);
    d_req = 1'b0;
    i_req = 1'b0;
    for (int c = 0; c < 10; c++) tick;

    // 4: watchdog
    mgr_hang = 1'b1;
    d_addr = 32'h3300_0080;
    d_we   = 1'b0;
    d_req  = 1'b1;
    tick;
    chk("t_ren", mem_ren, 1);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      tick;
      n++;
      if (d_ready) break;
    end
    chk("t_latency", n, 256);
    chk("t_rdy", d_ready, 1);
    chk("t_rdata", d_rdata, 0);
    chk("t_err", timeout_err, 1);
    d_req = 1'b0;
    mgr_hang = 1'b0;
    tick; tick;
    chk("t_err_sticky", timeout_err, 1);
    chk("t_rdy_pulse", d_ready, 0);

    // 5: reset in WAIT_DONE
    mgr_busy_cycles = 5;
    i_addr = 32'h3300_0100;
    i_req  = 1'b1;
    tick; tick; tick;
    chk("r_inflight", mem_addr, 32'h3300_0100);
    rst = 1'b1;
    #1;
    chk("r_async_addr", mem_addr, 0);
    chk("r_async_err", timeout_err, 0);
    chk("r_async_str", {mem_ren, mem_wen}, 0);
    i_req = 1'b0;
    tick;
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (i_ready || d_ready || mem_ren || mem_wen)
        n++;
    end
    chk("r_no_activity", n, 0);

    // 6: enable gating
    mgr_busy_cycles = 3;
    mgr_rdata = 32'h0000_0093;
    en     = 1'b0;
    i_addr = 32'h3300_0200;
    i_req  = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (mem_ren || mem_wen) n++;
    end
    chk("e_no_grant", n, 0);
    en = 1'b1;
    tick;
    chk("e_ren", mem_ren, 1);
    tick; tick;
    en = 1'b0;
    tick; tick; tick;
    chk("e_rdy", i_ready, 1);
    chk("e_rdata", i_rdata, 32'h93);
    i_req = 1'b0;
    d_req = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (mem_ren || mem_wen) n++;
    end
    chk("e_no_grant2", n, 0);
    d_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
